universal_shift_reg: RTL and testbench

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with enable, parallel load, shift, rotate, arithmetic shift and clear modes.
- Provides true and complemented outputs, a registered serial output, and a shift counter.
- The counter pulses `done` after WIDTH shift/rotate operations, marking a complete serial word transfer.
- Used as the generic storage/serialiser primitive for datapath and serial-link blocks.

---
 rtl/usr_pkg.sv | 29 ++
 rtl/usr_shift_counter.sv | 75 +++++++
 rtl/universal_shift_reg.sv | 152 +++++++++++++++
 tb/tb_universal_shift_reg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared types and helpers for the universal shift register.
//   usr_mode_e  : 3-bit operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/ASR/CLR)
//   cnt_width() : width of a counter able to hold the value w
//   even_par()  : XOR-reduce helper used when USR_PARITY_EN is defined
// -----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'd0,
        USR_LOAD = 3'd1,
        USR_SHL  = 3'd2,
        USR_SHR  = 3'd3,
        USR_ROL  = 3'd4,
        USR_ROR  = 3'd5,
        USR_ASR  = 3'd6,
        USR_CLR  = 3'd7
    } usr_mode_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// -----------------------------------------------------------------------------
// usr_shift_counter
// Counts shift-type operations and pulses done when a full WIDTH-bit word
// has been shifted; the count then wraps to zero.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-low reset
//   en        : operation enable (0 = hold count, done drops)
//   is_shift  : current mode is a shift/rotate (SHL..ASR)
//   clear     : current mode is LOAD or CLR (count restarts, no done)
//   shift_cnt : registered shift count
//   done      : registered one-cycle pulse on wrap
// -----------------------------------------------------------------------------
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             is_shift,
    input  logic             clear,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    // Next count / done: done only follows the shift that completes a word.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!en) begin
            cnt_d  = cnt_q;
            done_d = 1'b0;
        end else if (clear) begin
            cnt_d  = {CNT_W{1'b0}};
            done_d = 1'b0;
        end else if (is_shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = {CNT_W{1'b0}};
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_ONE;
                done_d = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            done_d = 1'b0;
        end
    end

    // Count and done registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// WIDTH-bit register with hold/load/shift/rotate/arithmetic-shift/clear modes,
// registered serial output and a word-completion shift counter.
// Optional macro: USR_PARITY_EN adds a registered even-parity output.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-low reset
//   en        : operation enable (0 = hold q/sout/count)
//   mode      : operation select (usr_mode_e encoding)
//   d         : parallel load data
//   sin       : serial input for SHL/SHR
//   q         : register contents
//   qb        : ~q (combinational)
//   sout      : registered bit shifted out by the last shift-type op
//   shift_cnt : shifts since last LOAD/CLR/wrap
//   parity    : (USR_PARITY_EN only) XOR-reduce of q, registered with q
//   done      : one-cycle pulse after WIDTH shifts
// -----------------------------------------------------------------------------
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic [CNT_W-1:0] shift_cnt,
`ifdef USR_PARITY_EN
    output logic             parity,
`endif
    output logic             done
);

    usr_mode_e        mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             sout_q;
    logic             sout_d;
    logic             is_shift_s;
    logic             clear_s;

    assign mode_s = usr_mode_e'(mode);

    // Datapath next-state: sout only moves on shift-type modes.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en) begin
            case (mode_s)
                USR_HOLD: q_d = q_q;
                USR_LOAD: q_d = d;
                USR_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                USR_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                USR_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                USR_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                USR_ASR: begin
                    q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                USR_CLR: q_d = {WIDTH{1'b0}};
                default: q_d = q_q;
            endcase
        end else begin
            q_d    = q_q;
            sout_d = sout_q;
        end
    end

    // Mode classification feeding the shift counter.
    always_comb begin
        is_shift_s = 1'b0;
        clear_s    = 1'b0;
        case (mode_s)
            USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR: is_shift_s = 1'b1;
            USR_LOAD, USR_CLR:                           clear_s    = 1'b1;
            default: begin
                is_shift_s = 1'b0;
                clear_s    = 1'b0;
            end
        endcase
    end

    // Data and serial-out registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity of the value q is about to take, so it tracks q cycle for cycle.
    always_comb begin
        parity_d = even_par(64'(q_d));
    end

    // Parity register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            parity_q <= even_par(64'(RESET_VAL));
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .is_shift  (is_shift_s),
        .clear     (clear_s),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    assign q    = q_q;
    assign qb   = ~q_q;
    assign sout = sout_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed self-checking bench for universal_shift_reg with WIDTH=8.
// Optional macro: USR_PARITY_EN connects and checks the parity output.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         sout;
    logic [3:0]   shift_cnt;
    logic         done;
`ifdef USR_PARITY_EN
    logic         parity;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin       (sin),
        .q         (q),
        .qb        (qb),
        .sout      (sout),
        .shift_cnt (shift_cnt),
`ifdef USR_PARITY_EN
        .parity    (parity),
`endif
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] dv, input logic s);
        en   = e;
        mode = m;
        d    = dv;
        sin  = s;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [W-1:0] a5;
        a5    = 8'hA5;
        reset = 1'b0;
        en    = 1'b1;
        mode  = M_LOAD;
        d     = 8'hFF;
        sin   = 1'b0;

        // Reset overrides an enabled LOAD.
        step(1'b1, M_LOAD, 8'hFF, 1'b0);
        step(1'b1, M_LOAD, 8'hFF, 1'b0);
        chk("rst_q", 64'(q), 64'h00);
        chk("rst_qb", 64'(qb), 64'hFF);
        chk("rst_sout", 64'(sout), 64'h0);
        chk("rst_cnt", 64'(shift_cnt), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        reset = 1'b1;

        // LOAD A5 then a full 8-bit SHL word.
        step(1'b1, M_LOAD, 8'hA5, 1'b0);
        chk("load_q", 64'(q), 64'hA5);
        chk("load_qb", 64'(qb), 64'h5A);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, M_SHL, 8'h00, 1'b0);
            chk($sformatf("shl_sout%0d", i), 64'(sout), 64'(a5[7-i]));
            chk($sformatf("shl_cnt%0d", i), 64'(shift_cnt), (i == 7) ? 64'h0 : 64'(i + 1));
            chk($sformatf("shl_done%0d", i), 64'(done), (i == 7) ? 64'h1 : 64'h0);
        end
        chk("shl_q", 64'(q), 64'h00);
        step(1'b1, M_HOLD, 8'h00, 1'b0);
        chk("hold_done", 64'(done), 64'h0);
        chk("hold_sout", 64'(sout), 64'h1);
        chk("hold_q", 64'(q), 64'h00);

        // Rotates and arithmetic shift.
        step(1'b1, M_LOAD, 8'h81, 1'b0);
        step(1'b1, M_ROR, 8'h00, 1'b0);
        chk("ror_q", 64'(q), 64'hC0);
        chk("ror_sout", 64'(sout), 64'h1);
        step(1'b1, M_ASR, 8'h00, 1'b0);
        chk("asr1_q", 64'(q), 64'hE0);
        step(1'b1, M_ASR, 8'h00, 1'b0);
        chk("asr2_q", 64'(q), 64'hF0);
        chk("asr2_sout", 64'(sout), 64'h0);
        step(1'b1, M_ROL, 8'h00, 1'b0);
        chk("rol_q", 64'(q), 64'hE1);
        chk("rol_sout", 64'(sout), 64'h1);
        chk("rol_cnt", 64'(shift_cnt), 64'h4);

        // CLR zeroes q and count, leaves sout.
        step(1'b1, M_CLR, 8'h00, 1'b0);
        chk("clr_q", 64'(q), 64'h00);
        chk("clr_cnt", 64'(shift_cnt), 64'h0);
        chk("clr_sout", 64'(sout), 64'h1);

        // SHR with enable gaps.
        step(1'b1, M_LOAD, 8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, M_SHR, 8'h00, 1'b1);
        chk("shr3_q", 64'(q), 64'hE7);
        chk("shr3_cnt", 64'(shift_cnt), 64'h3);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, M_SHR, 8'h00, 1'b1);
            chk($sformatf("en0_q%0d", i), 64'(q), 64'hE7);
            chk($sformatf("en0_cnt%0d", i), 64'(shift_cnt), 64'h3);
            chk($sformatf("en0_done%0d", i), 64'(done), 64'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, M_SHR, 8'h00, 1'b1);
            chk($sformatf("shr_done_early%0d", i), 64'(done), 64'h0);
        end
        chk("shr7_q", 64'(q), 64'hFE);
        chk("shr7_cnt", 64'(shift_cnt), 64'h7);
        step(1'b1, M_SHR, 8'h00, 1'b1);
        chk("shr8_q", 64'(q), 64'hFF);
        chk("shr8_done", 64'(done), 64'h1);
        chk("shr8_cnt", 64'(shift_cnt), 64'h0);
        step(1'b0, M_SHR, 8'h00, 1'b1);
        chk("shr_done_drop", 64'(done), 64'h0);

        // Reset mid-transfer discards the count.
        step(1'b1, M_LOAD, 8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, M_SHL, 8'h00, 1'b0);
        chk("mid_cnt5", 64'(shift_cnt), 64'h5);
        reset = 1'b0;
        step(1'b1, M_SHL, 8'h00, 1'b0);
        chk("mid_rst_q", 64'(q), 64'h00);
        chk("mid_rst_cnt", 64'(shift_cnt), 64'h0);
        chk("mid_rst_sout", 64'(sout), 64'h0);
        chk("mid_rst_done", 64'(done), 64'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, M_SHL, 8'h00, 1'b0);
            chk($sformatf("post_rst_done%0d", i), 64'(done), 64'h0);
        end
        chk("post_rst_cnt", 64'(shift_cnt), 64'h3);

        // LOAD mid-transfer restarts the count.
        step(1'b1, M_LOAD, 8'h12, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, M_SHL, 8'h00, 1'b0);
        chk("ld_mid_cnt6", 64'(shift_cnt), 64'h6);
        step(1'b1, M_LOAD, 8'h34, 1'b0);
        chk("ld_mid_cnt", 64'(shift_cnt), 64'h0);
        chk("ld_mid_done", 64'(done), 64'h0);
        chk("ld_mid_q", 64'(q), 64'h34);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, M_SHL, 8'h00, 1'b0);
            chk($sformatf("ld_post_done%0d", i), 64'(done), 64'h0);
        end
        chk("ld_post_cnt", 64'(shift_cnt), 64'h2);

`ifdef USR_PARITY_EN
        step(1'b1, M_LOAD, 8'h07, 1'b0);
        chk("par_load", 64'(parity), 64'h1);
        step(1'b1, M_SHL, 8'h00, 1'b1);
        chk("par_shl_q", 64'(q), 64'h0F);
        chk("par_shl", 64'(parity), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
